// File: rtl/ps2_kbd_receiver_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds scan-code prefixes, frame FSM states, the queued event record and the frame check.
package ps2_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    // Start bit low, stop bit high, odd parity over data+parity.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_kbd_receiver_if.sv
// Event stream between the PS/2 receiver (master) and a keyboard consumer (slave).
interface ps2_kbd_receiver_if #(
    parameter int LEVEL_W = 4
);
    logic               valid;
    logic               ready;
    logic [7:0]         code;
    logic               ext;
    logic               brk;
    logic [LEVEL_W-1:0] level;

    modport master (output valid, code, ext, brk, level, input ready);
    modport slave  (input valid, code, ext, brk, level, output ready);
endinterface

// File: rtl/ps2_kbd_receiver_event_fifo.sv
// First-word-fall-through synchronous FIFO for key events.
// Push while full is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                       i_clk,
    input  logic                       i_clr_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = DEPTH[AW:0];

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_push;

    assign o_level = r_wr - r_rd;
    assign o_empty = (o_level == '0);
    assign o_full  = (o_level == FULL_LVL);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
    end

    // Zero the head when empty so outputs read 0 while in reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: line sync/deglitch, 11-bit deframing with watchdog,
// E0/F0 prefix folding and a FWFT event queue with sticky overflow.
module ps2_kbd_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DECODE_EN      = 1
) (
    input  logic                       i_clk,
    input  logic                       i_clr_n,
    input  logic                       i_ps2_clk,
    input  logic                       i_ps2_data,
    ps2_kbd_receiver_if.master         evt,
    output logic                       o_overflow,
    input  logic                       i_ovf_clr,
    output logic                       o_frame_err,
    output logic [7:0]                 o_brk_count
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WDOG_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                  r_filt, r_filt_d;
    logic [FCNT_W-1:0]     r_fcnt;
    frame_state_t          r_state, w_next;
    logic [FRAME_BITS-1:0] r_bits;
    logic [3:0]            r_bit_cnt;
    logic [WDOG_W-1:0]     r_wdog;
    logic                  r_ext_f, r_brk_f;
    logic                  w_strobe, w_timeout, w_push, w_err, w_clr_f;
    logic                  w_set_ext, w_set_brk, w_is_brk;
    logic                  w_pop, w_full, w_empty, w_drop;
    logic [FIFO_AW:0]      w_level;
    kbd_event_t            w_wevt, w_revt;

    // Synchronisers idle high; the filter only follows a level held FILTER_LEN samples.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            {r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_filt, r_filt_d} <= '1;
            r_fcnt <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_strobe  = r_filt_d & ~r_filt;
    assign w_timeout = (r_state == SHIFT) && !w_strobe && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_strobe) w_next = SHIFT;
            SHIFT: begin
                if (w_timeout) w_next = IDLE;
                else if (w_strobe && r_bit_cnt == 4'(FRAME_BITS - 1)) w_next = CHECK;
            end
            CHECK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_push    = 1'b0;
        w_err     = 1'b0;
        w_clr_f   = 1'b0;
        w_set_ext = 1'b0;
        w_set_brk = 1'b0;
        w_is_brk  = 1'b0;
        case (r_state)
            SHIFT: if (w_timeout) begin
                w_err   = 1'b1;
                w_clr_f = 1'b1;
            end
            CHECK: begin
                if (!frame_ok(r_bits)) begin
                    w_err = 1'b1;
                end else begin
                    w_is_brk = (r_bits[8:1] == SC_BRK);
                    if (DECODE_EN != 0 && r_bits[8:1] == SC_EXT) begin
                        w_set_ext = 1'b1;
                    end else if (DECODE_EN != 0 && w_is_brk) begin
                        w_set_brk = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        w_clr_f = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_bits    <= '0;
            r_bit_cnt <= '0;
            r_wdog    <= '0;
        end else if (w_strobe) begin
            r_wdog <= '0;
            if (r_state == IDLE) begin
                r_bits[0] <= r_dat_s2;
                r_bit_cnt <= 4'd1;
            end else if (r_state == SHIFT) begin
                r_bits[r_bit_cnt] <= r_dat_s2;
                r_bit_cnt         <= r_bit_cnt + 1'b1;
            end
        end else if (r_state == SHIFT) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_pop  = evt.valid & evt.ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
            o_brk_count <= '0;
        end else begin
            if (w_clr_f)   {r_ext_f, r_brk_f} <= 2'b00;
            if (w_set_ext) r_ext_f <= 1'b1;
            if (w_set_brk) r_brk_f <= 1'b1;
            if (w_is_brk)  o_brk_count <= o_brk_count + 8'd1;
            o_frame_err <= w_err;
            o_overflow  <= w_drop | (o_overflow & ~i_ovf_clr);
        end
    end

    assign w_wevt = {r_ext_f, r_brk_f, r_bits[8:1]};

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(kbd_event_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clr_n (i_clr_n),
        .i_push  (w_push),
        .i_wdata (w_wevt),
        .i_pop   (w_pop),
        .o_rdata (w_revt),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign evt.valid = ~w_empty;
    assign evt.code  = w_revt.code;
    assign evt.ext   = w_revt.ext;
    assign evt.brk   = w_revt.brk;
    assign evt.level = w_level;

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Testbench for ps2_kbd_receiver: serial PS/2 frames in, queued key events checked via scoreboard.
module tb_ps2_kbd_receiver;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TMO   = 2000;
    localparam int LW    = $clog2(DEPTH) + 1;
    // 2-flop sync, FILTER_LEN filter samples, then strobe->CHECK->push (2 cycles)
    localparam int LAT   = 2 + FLEN + 2;

    logic clk = 1'b0, clr_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, sel1 = 1'b0;
    logic ovf_clr0 = 1'b0, ovf_clr1 = 1'b0;
    logic ovf0, ovf1, ferr0, ferr1;
    logic [7:0] brk0, brk1;
    logic d0_clk, d0_dat, d1_clk, d1_dat;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, edge_cyc = 0, rise_cyc = 0;
    int err_cnt0 = 0, err_cnt1 = 0, wide_err = 0;
    logic prev_v0 = 1'b0, prev_f0 = 1'b0, prev_f1 = 1'b0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         glitch;
        bit         push;
        logic [9:0] evt;
        int         err;
    } vec_t;
    vec_t tbl[6];

    assign d0_clk = sel1 ? 1'b1 : ps2_clk;
    assign d0_dat = sel1 ? 1'b1 : ps2_data;
    assign d1_clk = sel1 ? ps2_clk : 1'b1;
    assign d1_dat = sel1 ? ps2_data : 1'b1;

    ps2_kbd_receiver_if #(.LEVEL_W(LW)) if0 ();
    ps2_kbd_receiver_if #(.LEVEL_W(LW)) if1 ();

    ps2_kbd_receiver #(
        .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO), .DECODE_EN(1)
    ) dut0 (
        .i_clk(clk), .i_clr_n(clr_n), .i_ps2_clk(d0_clk), .i_ps2_data(d0_dat),
        .evt(if0), .o_overflow(ovf0), .i_ovf_clr(ovf_clr0),
        .o_frame_err(ferr0), .o_brk_count(brk0)
    );

    ps2_kbd_receiver #(
        .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO), .DECODE_EN(0)
    ) dut1 (
        .i_clk(clk), .i_clr_n(clr_n), .i_ps2_clk(d1_clk), .i_ps2_data(d1_dat),
        .evt(if1), .o_overflow(ovf1), .i_ovf_clr(ovf_clr1),
        .o_frame_err(ferr1), .o_brk_count(brk1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ferr0) err_cnt0++;
        if (ferr1) err_cnt1++;
        if ((ferr0 && prev_f0) || (ferr1 && prev_f1)) wide_err++;
        prev_f0 = ferr0;
        prev_f1 = ferr1;
        if (if0.valid && !prev_v0) rise_cyc = cyc;
        prev_v0 = if0.valid;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(25);
            ps2_clk  = 1'b0;
            edge_cyc = cyc;
            tick(50);
            ps2_clk = 1'b1;
            if (glitch && i == 3) begin
                tick(10);
                ps2_clk = 1'b0;
                tick(FLEN - 1);
                ps2_clk = 1'b1;
                tick(15);
            end else begin
                tick(25);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit flip, input bit glitch);
        send_frame(b, flip, glitch, 11);
        tick(60);
    endtask

    task automatic pop_expect(input int d, input string name);
        logic [9:0] exp, act;
        logic       v;
        int         t;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard has no entry to compare", name);
            return;
        end
        if (d == 0) exp = q0.pop_front();
        else        exp = q1.pop_front();
        t = 0;
        @(negedge clk);
        v = (d == 0) ? if0.valid : if1.valid;
        while (!v && t < 200) begin
            @(negedge clk);
            t++;
            v = (d == 0) ? if0.valid : if1.valid;
        end
        act = (d == 0) ? {if0.ext, if0.brk, if0.code} : {if1.ext, if1.brk, if1.code};
        check({name, " valid"}, int'(v), 1);
        check({name, " event"}, int'(act), int'(exp));
        if (d == 0) if0.ready = 1'b1;
        else        if1.ready = 1'b1;
        @(posedge clk);
        #1;
        if0.ready = 1'b0;
        if1.ready = 1'b0;
    endtask

    initial begin
        int e0, t;
        if0.ready = 1'b0;
        if1.ready = 1'b0;
        tbl[0] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
        tbl[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 0};
        tbl[2] = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h375, 0};
        tbl[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1};
        tbl[4] = '{8'h32, 1'b0, 1'b0, 1'b1, 10'h032, 0};
        tbl[5] = '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C, 0};

        tick(3);
        check("rst valid", int'(if0.valid), 0);
        check("rst level", int'(if0.level), 0);
        check("rst ovf", int'(ovf0), 0);
        check("rst ferr", int'(ferr0), 0);
        check("rst brkcnt", int'(brk0), 0);
        clr_n = 1'b1;
        tick(5);

        send(8'h1C, 1'b0, 1'b0);
        q0.push_back(10'h01C);
        check("latency", rise_cyc - edge_cyc, LAT);
        pop_expect(0, "basic 1C");
        check("basic drained valid", int'(if0.valid), 0);
        check("basic drained level", int'(if0.level), 0);

        foreach (tbl[i]) begin
            e0 = err_cnt0;
            send(tbl[i].code, tbl[i].flip, tbl[i].glitch);
            if (tbl[i].push) q0.push_back(tbl[i].evt);
            check($sformatf("vec%0d ferr", i), err_cnt0 - e0, tbl[i].err);
            check($sformatf("vec%0d level", i), int'(if0.level), q0.size());
        end
        while (q0.size() > 0) pop_expect(0, "vec drain");
        check("decode brkcnt", int'(brk0), 1);

        sel1 = 1'b1;
        tick(5);
        send(8'hE0, 1'b0, 1'b0); q1.push_back(10'h0E0);
        send(8'hF0, 1'b0, 1'b0); q1.push_back(10'h0F0);
        send(8'h75, 1'b0, 1'b0); q1.push_back(10'h075);
        check("raw level", int'(if1.level), 3);
        while (q1.size() > 0) pop_expect(1, "raw drain");
        check("raw brkcnt", int'(brk1), 1);
        sel1 = 1'b0;
        tick(5);

        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b0, 1'b0);
            if (i <= 8) q0.push_back(10'(i));
        end
        check("full level", int'(if0.level), 8);
        check("full ovf", int'(ovf0), 1);
        ovf_clr0 = 1'b1;
        tick(1);
        ovf_clr0 = 1'b0;
        check("ovf cleared", int'(ovf0), 0);

        fork
            send(8'h0A, 1'b0, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (!dut0.w_push && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                check("pushpop push seen", int'(dut0.w_push), 1);
                check("pushpop head", int'(if0.code), int'(q0[0][7:0]));
                void'(q0.pop_front());
                if0.ready = 1'b1;
                @(posedge clk);
                #1;
                if0.ready = 1'b0;
            end
        join
        q0.push_back(10'h00A);
        check("pushpop level", int'(if0.level), 8);
        check("pushpop ovf", int'(ovf0), 0);
        while (q0.size() > 0) pop_expect(0, "full drain");
        check("full drained level", int'(if0.level), 0);

        e0 = err_cnt0;
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        t = 0;
        while (err_cnt0 == e0 && t < TMO + 200) begin
            tick(1);
            t++;
        end
        check("wdog ferr", err_cnt0 - e0, 1);
        check("wdog level", int'(if0.level), 0);
        tick(20);
        send(8'h1C, 1'b0, 1'b0);
        q0.push_back(10'h01C);
        pop_expect(0, "after wdog");

        send(8'h11, 1'b0, 1'b0);
        check("pre-reset valid", int'(if0.valid), 1);
        send_frame(8'h55, 1'b0, 1'b0, 6);
        #3 clr_n = 1'b0;
        #1;
        check("midrst valid", int'(if0.valid), 0);
        check("midrst level", int'(if0.level), 0);
        check("midrst code", int'(if0.code), 0);
        check("midrst brkcnt", int'(brk0), 0);
        q0.delete();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        clr_n = 1'b1;
        tick(5);
        send(8'h29, 1'b0, 1'b0);
        q0.push_back(10'h029);
        pop_expect(0, "after reset");
        check("final level", int'(if0.level), 0);
        check("ferr pulse width", wide_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
